// File: rtl/lcd_pkg.sv
// lcd_pkg: timing helpers plus the state, command and init ROM definitions shared by the LCD text sequencer
package math_pkg;
  function automatic int vect_range(input int v);
    int r = 0;
    for (int i = 0; i < 32; i++) if ((v >> i) != 0) r = i;
    return r;
  endfunction
endpackage

package time_pkg;
  function automatic int nb_clk_for_time(input int freq_mhz, input int time_ns);
    longint p = longint'(freq_mhz) * longint'(time_ns);
    return int'((p + 999) / 1000);
  endfunction
endpackage

package lcd_pkg;
  typedef enum logic [1:0] {POWER_WAIT, INIT, FRAME, IDLE} state_t;
  typedef enum logic [1:0] {PH_LOAD, PH_SEND, PH_GAP, PH_WAIT} phase_t;
  localparam logic [7:0] FUNC_SET_8B_2L = 8'h38;
  localparam logic [7:0] DISP_ON = 8'h0C;
  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] ENTRY_INC = 8'h06;
  localparam logic [7:0] DDRAM_LINE0 = 8'h80;
  localparam logic [7:0] DDRAM_LINE1 = 8'hC0;
  localparam int INIT_LEN = 4;
  localparam int FRAME_LEN = 34;
  function automatic logic [7:0] init_rom(input logic [1:0] i);
    return i == 2'd0 ? FUNC_SET_8B_2L : i == 2'd1 ? DISP_ON : i == 2'd2 ? CLEAR : ENTRY_INC;
  endfunction
endpackage

// File: rtl/lcd_text_sequencer_if.sv
// lcd_text_sequencer_if: data/rs/start/ready handshake towards the LCD transaction controller
interface lcd_text_sequencer_if;
  logic [7:0] lcd_data;
  logic lcd_rs;
  logic lcd_start;
  logic lcd_ready;
  modport master(output lcd_data, output lcd_rs, output lcd_start, input lcd_ready);
  modport slave(input lcd_data, input lcd_rs, input lcd_start, output lcd_ready);
endinterface

// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: 32x8 character store, synchronous write, combinational read, resets to spaces
module lcd_text_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);
  logic [7:0] mem_q [32];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end
  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer: runs HD44780 power-on wait and init, then redraws the 2x16 text buffer on demand
module lcd_text_sequencer
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ_MZ = 50,
  parameter int POWER_ON_NS = 15_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_wr_en,
  input  logic [4:0] char_addr,
  input  logic [7:0] char_data,
  input  logic       refresh,
  output logic       busy,
  output logic       init_done,
  lcd_text_sequencer_if.master lcd
);
  localparam int POWER_ON = time_pkg::nb_clk_for_time(CLK_FREQ_MZ, POWER_ON_NS);
  localparam int CNT_W = math_pkg::vect_range(POWER_ON) + 1;
  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  logic [5:0] step_q, step_d, sel;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d, byte_nxt, rd_data;
  logic [4:0] rd_addr;
  logic rs_q, rs_d, start_q, start_d, init_done_q, init_done_d, busy_q, busy_d, pend_q, pend_d;
  logic rs_nxt, last, go, done;
  lcd_text_buffer u_buf (
    .clk(clk), .rst(reset), .wr_en(char_wr_en), .wr_addr(char_addr),
    .wr_data(char_data), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  // In WAIT the step index still names the transaction just sent, so look one ahead
  assign sel = phase_q == PH_WAIT ? step_q + 6'd1 : step_q;
  assign rd_addr = sel <= 6'd16 ? 5'(sel - 6'd1) : 5'(sel - 6'd2);
  assign last = step_q == (state_q == INIT ? 6'(INIT_LEN - 1) : 6'(FRAME_LEN - 1));
  assign go = lcd.lcd_ready && (phase_q == PH_LOAD || (phase_q == PH_WAIT && !last));
  assign done = lcd.lcd_ready && phase_q == PH_WAIT && last;
  assign byte_nxt = state_q == INIT ? init_rom(sel[1:0]) :
                    sel == 6'd0 ? DDRAM_LINE0 : sel == 6'd17 ? DDRAM_LINE1 : rd_data;
  assign rs_nxt = state_q == FRAME && sel != 6'd0 && sel != 6'd17;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d = step_q;
    cnt_d = cnt_q;
    data_d = data_q;
    rs_d = rs_q;
    start_d = 1'b0;
    init_done_d = init_done_q;
    pend_d = pend_q | ((refresh | char_wr_en) & (state_q != IDLE));
    unique case (state_q)
      POWER_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(POWER_ON)) begin
          state_d = INIT;
          phase_d = PH_LOAD;
          step_d = '0;
        end
      end
      INIT, FRAME: begin
        if (go) begin
          phase_d = PH_SEND;
          step_d = sel;
          start_d = 1'b1;
          data_d = byte_nxt;
          rs_d = rs_nxt;
        end else if (phase_q == PH_SEND) begin
          phase_d = PH_GAP;
        end else if (phase_q == PH_GAP) begin
          phase_d = PH_WAIT;
        end else if (done) begin
          state_d = state_q == INIT ? FRAME : IDLE;
          phase_d = PH_LOAD;
          step_d = '0;
          init_done_d = 1'b1;
          pend_d = state_q == INIT ? 1'b0 : pend_d;
        end
      end
      IDLE: begin
        if (pend_q | refresh | char_wr_en) begin
          state_d = FRAME;
          phase_d = PH_LOAD;
          step_d = '0;
          pend_d = 1'b0;
        end
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= POWER_WAIT;
      phase_q <= PH_LOAD;
      step_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      rs_q <= 1'b0;
      start_q <= 1'b0;
      init_done_q <= 1'b0;
      busy_q <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q <= step_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      rs_q <= rs_d;
      start_q <= start_d;
      init_done_q <= init_done_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end
  assign busy = busy_q;
  assign init_done = init_done_q;
  assign lcd.lcd_data = data_q;
  assign lcd.lcd_rs = rs_q;
  assign lcd.lcd_start = start_q;
endmodule

// File: tb/tb_lcd_text_sequencer.sv
// tb_lcd_text_sequencer: scoreboard of expected LCD transactions against a simple controller model
module tb_lcd_text_sequencer;
  localparam int LAT = 3;
  typedef struct {logic [7:0] d; logic rs;} txn_t;
  typedef struct {logic [4:0] addr; logic [7:0] data; logic with_refresh; int pos;} vec_t;
  logic clk = 1'b0, reset = 1'b1, char_wr_en = 1'b0, refresh = 1'b0, rdy = 1'b1, hold = 1'b0;
  logic [4:0] char_addr = '0;
  logic [7:0] char_data = '0;
  logic busy, init_done, prev_start = 1'b0;
  int lat = 0, cyc = 0, n_txn = 0, checks = 0, errors = 0;
  txn_t sb[$];
  logic [7:0] txn_log[$];
  int txn_cyc[$];
  logic [7:0] mbuf [32];
  vec_t vecs [4];
  lcd_text_sequencer_if lif();
  assign lif.lcd_ready = rdy;
  lcd_text_sequencer #(.CLK_FREQ_MZ(50), .POWER_ON_NS(1000)) dut (
    .clk(clk), .reset(reset), .char_wr_en(char_wr_en), .char_addr(char_addr),
    .char_data(char_data), .refresh(refresh), .busy(busy), .init_done(init_done), .lcd(lif)
  );
  always #5 clk = ~clk;
  // Controller model: ready drops the cycle after start, returns after LAT further cycles unless held
  always @(posedge clk) begin
    cyc <= reset ? 0 : cyc + 1;
    if (reset) begin
      rdy <= 1'b1;
      lat <= 0;
    end else if (lif.lcd_start) begin
      rdy <= 1'b0;
      lat <= LAT;
    end else if (lat > 0) begin
      lat <= lat - 1;
    end else if (!hold) begin
      rdy <= 1'b1;
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic push_init();
    sb.push_back('{8'h38, 1'b0});
    sb.push_back('{8'h0C, 1'b0});
    sb.push_back('{8'h01, 1'b0});
    sb.push_back('{8'h06, 1'b0});
  endtask
  task automatic push_frame();
    sb.push_back('{8'h80, 1'b0});
    for (int i = 0; i < 16; i++) sb.push_back('{mbuf[i], 1'b1});
    sb.push_back('{8'hC0, 1'b0});
    for (int i = 16; i < 32; i++) sb.push_back('{mbuf[i], 1'b1});
  endtask
  task automatic wait_txn(input int n, input int budget);
    int k = 0;
    while (n_txn < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("wait_txn_timeout", 32'(n_txn >= n), 32'd1);
  endtask
  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask
  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_start"}, 32'(lif.lcd_start), 32'd0);
    chk({tag, "_data"}, 32'(lif.lcd_data), 32'd0);
    chk({tag, "_rs"}, 32'(lif.lcd_rs), 32'd0);
  endtask
  initial begin
    int base, c, bad;
    logic [7:0] held;
    txn_t e;
    vecs[0] = '{5'd0, 8'h41, 1'b0, 1};
    vecs[1] = '{5'd31, 8'h42, 1'b0, 33};
    vecs[2] = '{5'd16, 8'h7E, 1'b1, 18};
    vecs[3] = '{5'd15, 8'h30, 1'b1, 16};
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    fork
      forever begin
        @(negedge clk);
        if (lif.lcd_start) begin
          chk("start_double_pulse", 32'(prev_start), 32'd0);
          txn_log.push_back(lif.lcd_data);
          txn_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            chk("unexpected_txn", 32'(lif.lcd_data), 32'hFFFF);
          end else begin
            e = sb.pop_front();
            chk($sformatf("txn%0d", n_txn), {23'd0, lif.lcd_rs, lif.lcd_data}, {23'd0, e.rs, e.d});
          end
          n_txn++;
        end
        prev_start = lif.lcd_start;
      end
    join_none
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    push_init();
    push_frame();
    reset = 1'b0;
    wait_txn(1, 200);
    if (n_txn >= 1) chk("first_start_cycle", 32'(txn_cyc[0]), 32'd52);
    wait_txn(4, 200);
    @(negedge clk);
    chk("init_done_before_frame", 32'(init_done), 32'd0);
    wait_txn(5, 200);
    @(negedge clk);
    chk("init_done_after_init", 32'(init_done), 32'd1);
    if (n_txn >= 2) chk("txn_spacing", 32'(txn_cyc[1] - txn_cyc[0]), 32'(LAT + 3));
    wait_idle(2000);
    @(posedge clk);
    chk("boot_txn_count", 32'(n_txn), 32'd38);
    chk("boot_sb_empty", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      base = n_txn;
      mbuf[vecs[i].addr] = vecs[i].data;
      push_frame();
      @(negedge clk);
      char_wr_en = 1'b1;
      char_addr = vecs[i].addr;
      char_data = vecs[i].data;
      refresh = vecs[i].with_refresh;
      @(negedge clk);
      char_wr_en = 1'b0;
      refresh = 1'b0;
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      wait_idle(2000);
      @(posedge clk);
      chk($sformatf("vec%0d_frame_len", i), 32'(n_txn - base), 32'd34);
      if (n_txn >= base + vecs[i].pos + 1)
        chk($sformatf("vec%0d_char", i), 32'(txn_log[base + vecs[i].pos]), 32'(vecs[i].data));
    end
    base = n_txn;
    push_frame();
    pulse_refresh();
    chk("refresh_busy_next", 32'(busy), 32'd1);
    chk("refresh_no_start_yet", 32'(lif.lcd_start), 32'd0);
    @(negedge clk);
    chk("refresh_first_send", 32'(lif.lcd_start), 32'd1);
    wait_idle(2000);
    base = n_txn;
    mbuf[20] = 8'h5A;
    push_frame();
    push_frame();
    pulse_refresh();
    wait_txn(base + 6, 500);
    @(negedge clk);
    char_wr_en = 1'b1;
    char_addr = 5'd20;
    char_data = 8'h5A;
    @(negedge clk);
    char_wr_en = 1'b0;
    wait_txn(base + 68, 4000);
    wait_idle(2000);
    repeat (20) @(negedge clk);
    chk("midwrite_two_frames", 32'(n_txn - base), 32'd68);
    if (n_txn >= base + 57) begin
      chk("midwrite_current_frame", 32'(txn_log[base + 22]), 32'h5A);
      chk("midwrite_extra_frame", 32'(txn_log[base + 56]), 32'h5A);
    end
    base = n_txn;
    push_frame();
    pulse_refresh();
    wait_txn(base + 1, 100);
    hold = 1'b1;
    @(negedge clk);
    held = lif.lcd_data;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (lif.lcd_start !== 1'b0 || lif.lcd_data !== held) bad++;
    end
    chk("hold_no_send", 32'(bad), 32'd0);
    chk("hold_txn_count", 32'(n_txn - base), 32'd1);
    c = cyc;
    hold = 1'b0;
    wait_txn(base + 2, 50);
    if (n_txn >= base + 2) chk("hold_release_send_cycle", 32'(txn_cyc[base + 1]), 32'(c + 2));
    wait_idle(2000);
    base = n_txn;
    push_frame();
    pulse_refresh();
    wait_txn(base + 3, 200);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    sb.delete();
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    push_init();
    push_frame();
    base = n_txn;
    reset = 1'b0;
    wait_txn(base + 1, 200);
    if (n_txn >= base + 1) chk("rerun_first_start_cycle", 32'(txn_cyc[base]), 32'd52);
    wait_txn(base + 38, 4000);
    wait_idle(2000);
    @(posedge clk);
    chk("rerun_txn_count", 32'(n_txn - base), 32'd38);
    chk("rerun_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_text_sequencer.md
# lcd_text_sequencer

Host-facing stage that sits directly upstream of the LCD transaction controller (`LCD_Controller`) and drives its `data`/`rs`/`start`/`ready` handshake. It owns a 2x16 character text buffer and runs the HD44780 power-on wait and init command sequence. It then redraws the full screen whenever a refresh is requested or the buffer is written. Host logic writes characters by address and never sequences LCD commands itself.

## Interface
- `CLK_FREQ_MZ`, default 50: clock frequency in MHz; all delays are derived from it through `time_pkg::nb_clk_for_time`.
- `POWER_ON_NS`, default 15_000_000: delay from reset release to the first init command.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `char_wr_en`  in  1  write strobe for the text buffer.
- `char_addr`  in  5  buffer address; 0-15 is line 0, 16-31 is line 1.
- `char_data`  in  8  character code to write.
- `refresh`  in  1  single-cycle pulse that requests a full redraw.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `init_done`  out  1  sticky; set once the init sequence has been sent.
- `lcd_data`  out  8  byte to the controller's `data` input.
- `lcd_rs`  out  1  to the controller's `rs` input: 0 = instruction, 1 = data.
- `lcd_start`  out  1  to the controller's `start` input; a one-cycle pulse.
- `lcd_ready`  in  1  from the controller's `ready` output.

## Operation
- Reset values:
  - `lcd_data`, `lcd_rs`, `lcd_start` = 0.
  - `init_done` = 0.
  - `busy` = 1, because the FSM resets into POWER_WAIT.
  - Every buffer entry = 0x20 (space).
  - Refresh-pending flag = 0.
- Buffer writes are accepted on any cycle, including during a redraw. A write during a redraw changes only the characters not yet sent.
- States:
  - POWER_WAIT: counts POWER_ON cycles, then goes to INIT.
  - INIT: sends init ROM entries 0x38, 0x0C, 0x01, 0x06 in that order, all with rs=0. After the last entry it sets `init_done` and goes to FRAME.
  - FRAME: sends 34 transactions in this order:
    - 0x80 (rs=0);
    - buffer[0..15] (rs=1);
    - 0xC0 (rs=0);
    - buffer[16..31] (rs=1).
    After the last one it goes to IDLE.
  - IDLE: goes to FRAME when the pending flag is set or `refresh` is high.
- Pending flag:
  - Set by `refresh` or `char_wr_en` in any state other than IDLE.
  - Cleared when FRAME is entered.
  - A write in IDLE starts a FRAME directly.
- Every transaction uses a three-phase handshake:
  - SEND: entered only when `lcd_ready`=1. `lcd_start`=1 for exactly this cycle, with `lcd_data`/`lcd_rs` valid.
  - GAP: one cycle in which `lcd_ready` is ignored. This covers the controller's registered drop of `ready`.
  - WAIT: holds until `lcd_ready`=1, then either issues the next SEND on the following cycle or exits.
- `lcd_data`/`lcd_rs` are loaded on entry to SEND. They stay unchanged until the next SEND.
- Frame step index is 6 bits, range 0-33. The character address is derived from the step index: step-1 for steps 1-16, step-2 for steps 18-33.
- `refresh` and `char_wr_en` arriving on the same cycle produce one pending redraw, not two.
- Reset mid-transaction: all state returns to reset values and the buffer is cleared to spaces. The controller is reset by the same signal, so no handshake is left dangling.

## Timing
- All outputs are registered. `lcd_start` is never high on two consecutive cycles.
- POWER_ON = `time_pkg::nb_clk_for_time(CLK_FREQ_MZ, POWER_ON_NS)`.
  - The counter width is `math_pkg::vect_range(POWER_ON)+1`.
  - The first `lcd_start` occurs POWER_ON+2 cycles after reset deasserts, provided `lcd_ready`=1.
- Back-to-back transactions are separated by the controller's latency plus 2 cycles (GAP + WAIT exit). No internal delay is added; the controller enforces the LCD's execution times.
- `refresh` seen in IDLE: `busy` rises the next cycle, and the first SEND follows on the cycle after that when `lcd_ready`=1.
- The buffer read is combinational from the step index. Data is captured into `lcd_data` in the same cycle it is read.

## Structure
- Shared package `lcd_pkg` holds:
  - the state enum;
  - command constants: FUNC_SET_8B_2L=0x38, DISP_ON=0x0C, CLEAR=0x01, ENTRY_INC=0x06, DDRAM_LINE0=0x80, DDRAM_LINE1=0xC0;
  - INIT_LEN=4 and an init ROM function;
  - FRAME_LEN=34.
- Sub-module `lcd_text_buffer`: a 32x8 register array.
  - Synchronous write; combinational read.
  - Synchronous reset fills every entry with 0x20.
- The top level contains the FSM, POWER_WAIT counter, step index, pending flag and output registers.

## Test plan
- Reset release with POWER_ON_NS=1000 and CLK_FREQ_MZ=50 (POWER_ON=50 cycles) → first `lcd_start` at cycle 52 with data 0x38, rs=0; then 0x0C, 0x01, 0x06; `init_done` rises after 0x06.
- After init with default buffer → 34 transactions: 0x80, 16×0x20 (rs=1), 0xC0, 16×0x20; then `busy`=0.
- Write 0x41 to addr 0 and 0x42 to addr 31, then pulse `refresh` in IDLE → exactly one frame; second transaction is 0x41 (rs=1); last transaction is 0x42.
- Write addr 20 = 0x5A during a FRAME that is at step 5 → current frame sends 0x5A at step 22; one extra frame follows with 0x5A again.
- Bench holds `lcd_ready`=0 for 200 cycles after a GAP → `lcd_start` stays 0 and `lcd_data` holds its value; SEND occurs 1 cycle after `lcd_ready` rises.
- Assert `reset` in a FRAME WAIT phase → next cycle all outputs are at reset values, the buffer reads 0x20, and the init sequence repeats.
